// File: rtl/instr_register_pkg.sv
// Shared types and constants for the ALU-backed instruction register.
package instr_register_pkg;

    // Operation selector; all eight encodings are assigned.
    typedef enum logic [2:0] {
        ZERO  = 3'd0,
        PASSA = 3'd1,
        PASSB = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        MULT  = 3'd5,
        DIV   = 3'd6,
        MOD   = 3'd7
    } opcode_t;

    localparam int DEFAULT_OP_WIDTH = 32;
    localparam int DEFAULT_DEPTH    = 32;

    // instruction_word fields, listed from most to least significant:
    // {opc[2:0], op_a[OP_WIDTH], op_b[OP_WIDTH], result[RES_WIDTH], div_err}
    typedef enum logic [2:0] {
        FLD_OPC,
        FLD_OP_A,
        FLD_OP_B,
        FLD_RESULT,
        FLD_DIV_ERR
    } word_field_t;

    // Total width of one packed instruction word.
    function automatic int word_width(input int op_width, input int res_width);
        return 3 + 2 * op_width + res_width + 1;
    endfunction

    // Bit position of the least significant bit of a field in the word.
    function automatic int field_lsb(input word_field_t fld, input int op_width,
                                     input int res_width);
        case (fld)
            FLD_DIV_ERR: return 0;
            FLD_RESULT:  return 1;
            FLD_OP_B:    return 1 + res_width;
            FLD_OP_A:    return 1 + res_width + op_width;
            default:     return 1 + res_width + 2 * op_width;
        endcase
    endfunction

endpackage

// File: rtl/instr_alu.sv
// Combinational signed ALU; every result is sign-extended to RES_WIDTH.
module instr_alu
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = DEFAULT_OP_WIDTH,
    parameter int RES_WIDTH = 2 * OP_WIDTH
) (
    input  opcode_t                       opcode,
    input  logic signed [OP_WIDTH-1:0]    operand_a,
    input  logic signed [OP_WIDTH-1:0]    operand_b,
    output logic signed [RES_WIDTH-1:0]   result,
    output logic                          div_err
);

    // Operands widened first so MULT keeps the full product and
    // DIV of the most negative value by -1 cannot overflow.
    logic signed [RES_WIDTH-1:0] a_ext;
    logic signed [RES_WIDTH-1:0] b_ext;

    assign a_ext = {{(RES_WIDTH - OP_WIDTH){operand_a[OP_WIDTH-1]}}, operand_a};
    assign b_ext = {{(RES_WIDTH - OP_WIDTH){operand_b[OP_WIDTH-1]}}, operand_b};

    // Operation decode; a zero divisor yields 0 and raises div_err.
    always_comb begin
        result  = '0;
        div_err = 1'b0;
        case (opcode)
            ZERO:  result = '0;
            PASSA: result = a_ext;
            PASSB: result = b_ext;
            ADD:   result = a_ext + b_ext;
            SUB:   result = a_ext - b_ext;
            MULT:  result = a_ext * b_ext;
            DIV: begin
                if (b_ext == '0) div_err = 1'b1;
                else             result  = a_ext / b_ext;
            end
            MOD: begin
                if (b_ext == '0) div_err = 1'b1;
                else             result  = a_ext % b_ext;
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/instr_register_alu.sv
// Instruction register with write-time ALU, auto-increment writes,
// per-entry valid bits, occupancy/full status, bulk clear and a registered read.
module instr_register_alu
    import instr_register_pkg::*;
#(
    parameter int OP_WIDTH  = DEFAULT_OP_WIDTH,
    parameter int RES_WIDTH = 2 * OP_WIDTH,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          load_en,
    input  logic                                          wr_auto,
    input  logic [AW-1:0]                                 write_pointer,
    input  opcode_t                                       opcode,
    input  logic signed [OP_WIDTH-1:0]                    operand_a,
    input  logic signed [OP_WIDTH-1:0]                    operand_b,
    input  logic                                          clear,
    input  logic                                          rd_en,
    input  logic [AW-1:0]                                 read_pointer,
    output logic [word_width(OP_WIDTH, RES_WIDTH)-1:0]    instruction_word,
    output logic                                          rd_valid,
    output logic                                          rd_hit,
    output logic [AW-1:0]                                 wr_ptr_q,
    output logic [AW:0]                                   valid_count,
    output logic                                          full
);

    typedef struct packed {
        opcode_t                     opc;
        logic signed [OP_WIDTH-1:0]  op_a;
        logic signed [OP_WIDTH-1:0]  op_b;
        logic signed [RES_WIDTH-1:0] result;
        logic                        div_err;
    } entry_t;

    entry_t                      mem [DEPTH];
    logic [DEPTH-1:0]            valid_q;
    entry_t                      wr_entry;
    entry_t                      rd_entry_p1;
    logic signed [RES_WIDTH-1:0] alu_result;
    logic                        alu_div_err;

    logic [DEPTH-1:0] valid_base;
    logic [DEPTH-1:0] valid_next;
    logic [AW-1:0]    ptr_base;
    logic [AW-1:0]    ptr_next;
    logic [AW:0]      count_base;
    logic [AW:0]      count_next;
    logic [AW-1:0]    wr_addr;

    instr_alu #(
        .OP_WIDTH  (OP_WIDTH),
        .RES_WIDTH (RES_WIDTH)
    ) u_alu (
        .opcode    (opcode),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .result    (alu_result),
        .div_err   (alu_div_err)
    );

    assign wr_entry = '{opc: opcode, op_a: operand_a, op_b: operand_b,
                        result: alu_result, div_err: alu_div_err};

    // Control next-state: clear is folded in first so a same-cycle write
    // lands on the cleared state (auto writes then target index 0).
    always_comb begin
        valid_base = clear ? '0 : valid_q;
        ptr_base   = clear ? '0 : wr_ptr_q;
        count_base = clear ? '0 : valid_count;
        wr_addr    = wr_auto ? ptr_base : write_pointer;
        valid_next = valid_base;
        ptr_next   = ptr_base;
        count_next = count_base;
        if (load_en) begin
            valid_next[wr_addr] = 1'b1;
            // Only a write to an empty slot grows occupancy, so it never exceeds DEPTH.
            if (!valid_base[wr_addr]) count_next = count_base + (AW+1)'(1);
            if (wr_auto)              ptr_next   = ptr_base + AW'(1);
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q     <= '0;
            wr_ptr_q    <= '0;
            valid_count <= '0;
        end else begin
            valid_q     <= valid_next;
            wr_ptr_q    <= ptr_next;
            valid_count <= count_next;
        end
    end

    // Entry storage; data survives clear, only the valid bits drop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (load_en) begin
            mem[wr_addr] <= wr_entry;
        end
    end

    // Read stage p1: samples pre-write contents, so same-address read/write is read-before-write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid    <= 1'b0;
            rd_hit      <= 1'b0;
            rd_entry_p1 <= '0;
        end else begin
            rd_valid <= rd_en;
            rd_hit   <= rd_en && valid_q[read_pointer];
            if (rd_en) rd_entry_p1 <= valid_q[read_pointer] ? mem[read_pointer] : '0;
        end
    end

    assign instruction_word = rd_entry_p1;
    assign full             = (valid_count == (AW+1)'(DEPTH));

endmodule

// File: tb/tb_instr_register_alu.sv
// Self-checking bench: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_instr_register_alu;
    import instr_register_pkg::*;

    localparam int OP_WIDTH  = 32;
    localparam int RES_WIDTH = 64;
    localparam int DEPTH     = 8;
    localparam int AW        = 3;
    localparam int WORD_W    = 3 + 2 * OP_WIDTH + RES_WIDTH + 1;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic                       load_en = 1'b0;
    logic                       wr_auto = 1'b0;
    logic [AW-1:0]              write_pointer = '0;
    opcode_t                    opcode = ZERO;
    logic signed [OP_WIDTH-1:0] operand_a = '0;
    logic signed [OP_WIDTH-1:0] operand_b = '0;
    logic                       clear = 1'b0;
    logic                       rd_en = 1'b0;
    logic [AW-1:0]              read_pointer = '0;
    logic [WORD_W-1:0]          instruction_word;
    logic                       rd_valid;
    logic                       rd_hit;
    logic [AW-1:0]              wr_ptr_q;
    logic [AW:0]                valid_count;
    logic                       full;

    instr_register_alu #(
        .OP_WIDTH  (OP_WIDTH),
        .RES_WIDTH (RES_WIDTH),
        .DEPTH     (DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .load_en          (load_en),
        .wr_auto          (wr_auto),
        .write_pointer    (write_pointer),
        .opcode           (opcode),
        .operand_a        (operand_a),
        .operand_b        (operand_b),
        .clear            (clear),
        .rd_en            (rd_en),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .rd_valid         (rd_valid),
        .rd_hit           (rd_hit),
        .wr_ptr_q         (wr_ptr_q),
        .valid_count      (valid_count),
        .full             (full)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit check_on = 0;

    // Behavioural model state: contents per index, valid flags, auto pointer.
    opcode_t           m_opc   [DEPTH];
    longint            m_a     [DEPTH];
    longint            m_b     [DEPTH];
    longint            m_res   [DEPTH];
    bit                m_err   [DEPTH];
    bit                m_valid [DEPTH];
    int                m_ptr;
    logic [WORD_W-1:0] exp_word;
    bit                exp_rd_valid;
    bit                exp_rd_hit;

    task automatic chk_int(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic chk_word(input string name, input logic [WORD_W-1:0] act,
                            input logic [WORD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic longint alu_ref(input opcode_t op, input longint a, input longint b,
                                       output bit err);
        err = 0;
        case (op)
            PASSA:   return a;
            PASSB:   return b;
            ADD:     return a + b;
            SUB:     return a - b;
            MULT:    return a * b;
            DIV:     begin if (b == 0) begin err = 1; return 0; end return a / b; end
            MOD:     begin if (b == 0) begin err = 1; return 0; end return a % b; end
            default: return 0;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] pack(input int i);
        longint a, b, r;
        a = m_a[i];
        b = m_b[i];
        r = m_res[i];
        return {m_opc[i], a[OP_WIDTH-1:0], b[OP_WIDTH-1:0], r[RES_WIDTH-1:0], m_err[i]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_opc[i] = ZERO; m_a[i] = 0; m_b[i] = 0; m_res[i] = 0;
            m_err[i] = 0; m_valid[i] = 0;
        end
        m_ptr = 0;
        exp_word = '0;
        exp_rd_valid = 0;
        exp_rd_hit = 0;
    endtask

    // One clock of the model, using the inputs presented to this edge.
    task automatic model_step();
        int idx;
        bit e;
        longint r;
        if (rd_en) begin
            exp_rd_valid = 1;
            exp_rd_hit   = m_valid[read_pointer];
            exp_word     = m_valid[read_pointer] ? pack(int'(read_pointer)) : '0;
        end else begin
            exp_rd_valid = 0;
            exp_rd_hit   = 0;
        end
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
            m_ptr = 0;
        end
        if (load_en) begin
            idx = wr_auto ? m_ptr : int'(write_pointer);
            r = alu_ref(opcode, longint'(operand_a), longint'(operand_b), e);
            m_opc[idx] = opcode; m_a[idx] = operand_a; m_b[idx] = operand_b;
            m_res[idx] = r; m_err[idx] = e; m_valid[idx] = 1;
            if (wr_auto) m_ptr = (m_ptr + 1) % DEPTH;
        end
    endtask

    // Compare DUT outputs against the model on every falling edge.
    always @(negedge clk) begin : compare
        int cnt;
        if (check_on) begin
            cnt = 0;
            for (int i = 0; i < DEPTH; i++) if (m_valid[i]) cnt++;
            chk_word("instruction_word", instruction_word, exp_word);
            chk_int("rd_valid", longint'(rd_valid), longint'(exp_rd_valid));
            chk_int("rd_hit", longint'(rd_hit), longint'(exp_rd_hit));
            chk_int("wr_ptr_q", longint'(wr_ptr_q), longint'(m_ptr));
            chk_int("valid_count", longint'(valid_count), longint'(cnt));
            chk_int("full", longint'(full), longint'(cnt == DEPTH));
        end
    end

    // Advance one clock; inputs change 1 time unit after the falling edge.
    task automatic step();
        @(posedge clk);
        if (!reset) model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_idle();
        load_en = 0; wr_auto = 0; clear = 0; rd_en = 0;
    endtask

    task automatic wr(input bit auto_mode, input int wp, input opcode_t op,
                      input int a, input int b);
        set_idle();
        load_en = 1; wr_auto = auto_mode; write_pointer = AW'(wp);
        opcode = op; operand_a = a; operand_b = b;
        step();
        load_en = 0;
    endtask

    task automatic rd(input int rp);
        set_idle();
        rd_en = 1; read_pointer = AW'(rp);
        step();
        rd_en = 0;
    endtask

    task automatic expect_read(input string name, input bit hit, input longint res,
                               input bit err);
        chk_int({name, " rd_valid"}, longint'(rd_valid), 1);
        chk_int({name, " rd_hit"}, longint'(rd_hit), longint'(hit));
        chk_int({name, " result"}, $signed(instruction_word[RES_WIDTH:1]), res);
        chk_int({name, " div_err"}, longint'(instruction_word[0]), longint'(err));
    endtask

    function automatic logic signed [OP_WIDTH-1:0] rand_op();
        int v;
        case ($urandom_range(0, 3))
            0: begin v = int'($urandom_range(0, 40)) - 20; return v; end
            1: return $urandom;
            2: begin
                case ($urandom_range(0, 3))
                    0: v = 32'h8000_0000;
                    1: v = 32'h7fff_ffff;
                    2: v = -1;
                    default: v = 0;
                endcase
                return v;
            end
            default: begin v = int'($urandom_range(0, 2000)) - 1000; return v; end
        endcase
    endfunction

    initial begin
        model_reset();
        check_on = 1;

        // Reset held with a write and a read requested: nothing may happen.
        load_en = 1; wr_auto = 1; opcode = ADD; operand_a = 5; operand_b = 6;
        rd_en = 1; read_pointer = 3;
        step();
        step();
        chk_word("reset word", instruction_word, '0);
        chk_int("reset rd_valid", longint'(rd_valid), 0);
        chk_int("reset count", longint'(valid_count), 0);
        chk_int("reset ptr", longint'(wr_ptr_q), 0);
        set_idle();
        reset = 0;
        step();
        chk_int("post-reset rd_valid", longint'(rd_valid), 0);

        rd(5);
        expect_read("empty read 5", 0, 0, 0);
        chk_word("empty read word", instruction_word, '0);

        wr(1, 0, ADD, 7, -3);
        wr(1, 0, SUB, 4, 9);
        wr(1, 0, MULT, -6, 5);
        chk_int("ptr after 3", longint'(wr_ptr_q), 3);
        chk_int("count after 3", longint'(valid_count), 3);
        rd(0); expect_read("ADD", 1, 4, 0);
        rd(1); expect_read("SUB", 1, -5, 0);
        rd(2); expect_read("MULT", 1, -30, 0);

        wr(1, 0, DIV, -7, 2);
        wr(1, 0, MOD, -7, 2);
        wr(1, 0, DIV, 5, 0);
        rd(3); expect_read("DIV", 1, -3, 0);
        rd(4); expect_read("MOD", 1, -1, 0);
        rd(5); expect_read("DIV0", 1, 0, 1);

        // Fill, then one more auto write wraps onto entry 0.
        wr(1, 0, PASSA, 100, 0);
        chk_int("full before last", longint'(full), 0);
        wr(1, 0, PASSA, 101, 0);
        chk_int("full at depth", longint'(full), 1);
        chk_int("count at depth", longint'(valid_count), DEPTH);
        chk_int("ptr wrapped", longint'(wr_ptr_q), 0);
        wr(1, 0, PASSA, 55, 0);
        chk_int("count saturated", longint'(valid_count), DEPTH);
        chk_int("ptr after wrap", longint'(wr_ptr_q), 1);
        chk_int("still full", longint'(full), 1);
        rd(0); expect_read("overwrite 0", 1, 55, 0);

        // Same-cycle write and read of one address returns the old contents.
        wr(0, 2, PASSA, 99, 0);
        chk_int("explicit write keeps ptr", longint'(wr_ptr_q), 1);
        set_idle();
        load_en = 1; wr_auto = 0; write_pointer = 2; opcode = PASSA;
        operand_a = 11; operand_b = 0; rd_en = 1; read_pointer = 2;
        step();
        set_idle();
        expect_read("read-before-write", 1, 99, 0);
        rd(2); expect_read("after write", 1, 11, 0);

        // Clear together with an auto write.
        set_idle();
        clear = 1; load_en = 1; wr_auto = 1; opcode = PASSB; operand_a = 0; operand_b = 8;
        step();
        set_idle();
        chk_int("clear+write count", longint'(valid_count), 1);
        chk_int("clear+write ptr", longint'(wr_ptr_q), 1);
        chk_int("clear+write full", longint'(full), 0);
        rd(0); expect_read("clear entry 0", 1, 8, 0);
        rd(1);
        chk_int("cleared entry hit", longint'(rd_hit), 0);
        chk_word("cleared entry word", instruction_word, '0);

        // Reset arriving while a read is pending.
        rd_en = 1; read_pointer = 0; reset = 1; model_reset();
        step();
        reset = 0; set_idle();
        step();
        chk_int("pending read dropped", longint'(rd_valid), 0);
        chk_int("count after reset", longint'(valid_count), 0);

        // Randomized traffic against the model.
        for (int n = 0; n < 800; n++) begin
            load_en       = ($urandom_range(0, 1) == 1);
            wr_auto       = ($urandom_range(0, 1) == 1);
            write_pointer = AW'($urandom_range(0, DEPTH - 1));
            opcode        = opcode_t'($urandom_range(0, 7));
            operand_a     = rand_op();
            operand_b     = ($urandom_range(0, 7) == 0) ? '0 : rand_op();
            clear         = ($urandom_range(0, 29) == 0);
            rd_en         = ($urandom_range(0, 9) < 6);
            read_pointer  = AW'($urandom_range(0, DEPTH - 1));
            step();
        end
        set_idle();
        step();

        check_on = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_register_alu.md
Name: instr_register_alu

Overview:
Parametrised successor to the instruction register. It stores DEPTH entries, each holding an opcode, two operands, a computed result and a divide-error flag. The result is calculated at write time by an internal ALU and held alongside the instruction. The block adds an auto-increment write mode, per-entry valid tracking, occupancy and full status, a bulk clear, and a registered read port with a valid/hit handshake. It sits between the stimulus/issue logic and the scoreboard/readback path.

Parameters:
OP_WIDTH, 32, signed operand width in bits.
RES_WIDTH, 2*OP_WIDTH, signed result width in bits; must be at least OP_WIDTH+1.
DEPTH, 32, number of entries; power of two, minimum 2.
AW, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
load_en  in  1  write strobe
wr_auto  in  1  1: write to internal pointer wr_ptr_q; 0: write to write_pointer
write_pointer  in  AW  explicit write address
opcode  in  3  opcode_t: ZERO, PASSA, PASSB, ADD, SUB, MULT, DIV, MOD
operand_a  in  OP_WIDTH  signed operand A
operand_b  in  OP_WIDTH  signed operand B
clear  in  1  synchronous clear of all valid bits and of the auto pointer
rd_en  in  1  read request
read_pointer  in  AW  read address
instruction_word  out  3+2*OP_WIDTH+RES_WIDTH+1  registered {opc, op_a, op_b, result, div_err}
rd_valid  out  1  one-cycle pulse one cycle after rd_en
rd_hit  out  1  qualifies rd_valid; 1 when the entry read was valid
wr_ptr_q  out  AW  current auto-write pointer
valid_count  out  AW+1  number of valid entries
full  out  1  valid_count == DEPTH

Behaviour:
- Reset: every output is 0; all entries are 0 and invalid; wr_ptr_q is 0. Reset asserted mid-operation discards any pending read; rd_valid is 0 on the first edge after reset is released.
- Write: on a clk edge with load_en=1, the target entry captures opcode, the operands, the ALU result and div_err, and its valid bit is set. The entry is readable from the next edge onward.
- Auto mode: with wr_auto=1, the target is wr_ptr_q, which then increments and wraps from DEPTH-1 to 0. With wr_auto=0, wr_ptr_q does not change.
- valid_count: increments only when a write lands on an invalid entry. Overwriting a valid entry leaves the count unchanged. The count saturates at DEPTH.
- full: asserted while valid_count == DEPTH. Writes while full are still accepted and simply overwrite.
- clear: sets all valid bits to 0, valid_count to 0 and wr_ptr_q to 0. Data is retained but reads of it report rd_hit=0.
  - clear and load_en in the same cycle: the clear applies first, then the write. The written entry ends valid, valid_count=1, and in auto mode the write lands at index 0 and wr_ptr_q becomes 1.
- Read: rd_en at edge N sets rd_valid=1 after edge N for one cycle, and instruction_word holds the addressed entry.
  - If the entry is invalid: instruction_word=0 and rd_hit=0.
  - If rd_en is held high, a read is performed every cycle.
  - instruction_word holds its last value when rd_en=0.
- Same-cycle read and write to the same address: read-before-write; the read returns the pre-write contents and hit status.
- ALU (signed): all results are sign-extended to RES_WIDTH.
  - ZERO → 0; PASSA → a; PASSB → b.
  - ADD → a+b; SUB → a-b; MULT → a*b (full product).
  - DIV → a/b, truncating toward zero; MOD → a%b, sign of the dividend.
  - DIV or MOD with b==0 → result 0 and div_err=1. div_err is 0 in all other cases.
- Undefined opcode encodings cannot occur: the opcode is 3 bits and all 8 values are assigned.

Decomposition:
- instr_register_pkg holds:
  - opcode_t, unchanged;
  - constants DEFAULT_OP_WIDTH=32 and DEFAULT_DEPTH=32;
  - field order for instruction_word.
- Width-dependent struct typedefs are declared inside the module from the parameters.
- One sub-module, instr_alu: combinational, parametrised by OP_WIDTH and RES_WIDTH, producing result and div_err.

Test Plan:
- Reset with load_en=1 active → all outputs 0; after release, rd_en to address 5 → rd_valid=1, rd_hit=0, instruction_word=0.
- Auto writes of ADD(7,-3), SUB(4,9), MULT(-6,5) → wr_ptr_q=3, valid_count=3; reads at 0/1/2 return results 4, -5, -30 with rd_hit=1.
- DIV(-7,2) → result -3; MOD(-7,2) → result -1; DIV(5,0) → result 0 with div_err=1.
- DEPTH=4 build: 5 auto writes → full=1 after the 4th write, wr_ptr_q wraps to 1, valid_count stays 4, and entry 0 holds the 5th write.
- Same-cycle write PASSA(11,0) and read of address 2, where address 2 previously held 99 → read returns 99; the next read returns 11.
- clear together with an auto write PASSB(0,8) → valid_count=1, wr_ptr_q=1; a read of 0 returns 8 with rd_hit=1, and a read of 1 gives rd_hit=0.
